// File: rtl/instr_sequencer_if.sv
// Bus bundle between the instruction sequencer (master) and its pipe-in,
// device mux, register file and pipe-out neighbours (slave).
interface instr_sequencer_if #(
  parameter int REG_AW = 4
);
  logic              instr_valid;
  logic [15:0]       instr_data;
  logic              instr_ready;
  logic              mux_valid;
  logic [7:0]        mux_addr;
  logic [3:0]        mux_cmd;
  logic [11:0]       mux_data;
  logic              mux_ready;
  logic              reg_we;
  logic [REG_AW-1:0] reg_addr;
  logic [23:0]       reg_wdata;
  logic [23:0]       reg_rdata;
  logic              out_valid;
  logic [15:0]       out_data;
  logic              out_ready;
  logic              busy;

  modport master (
    input  instr_valid, instr_data, mux_ready, reg_rdata, out_ready,
    output instr_ready, mux_valid, mux_addr, mux_cmd, mux_data,
           reg_we, reg_addr, reg_wdata, out_valid, out_data, busy
  );

  modport slave (
    output instr_valid, instr_data, mux_ready, reg_rdata, out_ready,
    input  instr_ready, mux_valid, mux_addr, mux_cmd, mux_data,
           reg_we, reg_addr, reg_wdata, out_valid, out_data, busy
  );
endinterface

// File: rtl/instr_sequencer.sv
// Single-issue executor for the 16-bit host instruction stream: decodes each
// word and drives the device mux, control registers, wait timer or pipe-out.
module instr_sequencer #(
  parameter int REG_AW = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  instr_sequencer_if.master       bus_if
);
  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_MUXREQ, S_WAIT, S_RD_LO, S_RD_HI
  } state_t;

  localparam logic [2:0] OP_SETSR = 3'd1;
  localparam logic [2:0] OP_LDSR  = 3'd2;
  localparam logic [2:0] OP_MUX   = 3'd3;
  localparam logic [2:0] OP_MUXE  = 3'd4;
  localparam logic [2:0] OP_WAIT  = 3'd5;
  localparam logic [2:0] OP_LDREG = 3'd6;
  localparam logic [2:0] OP_RDREG = 3'd7;

  state_t             r_state, w_state_next;
  logic [15:0]        r_ir, w_ir_next;
  logic [1:0][23:0]   r_sr, w_sr_next;
  logic [23:0]        r_rb, w_rb_next;
  logic [23:0]        r_cnt, w_cnt_next;
  logic               r_mux_valid, w_mux_valid_next;
  logic [7:0]         r_mux_addr, w_mux_addr_next;
  logic [3:0]         r_mux_cmd, w_mux_cmd_next;
  logic [11:0]        r_mux_data, w_mux_data_next;
  logic               r_reg_we, w_reg_we_next;
  logic [REG_AW-1:0]  r_reg_addr, w_reg_addr_next;
  logic [23:0]        r_reg_wdata, w_reg_wdata_next;
  logic               r_out_valid, w_out_valid_next;
  logic [15:0]        r_out_data, w_out_data_next;

  logic [2:0]  w_op;
  logic        w_ireg;
  logic [11:0] w_data;
  logic [23:0] w_sr_sel;

  assign w_op     = r_ir[15:13];
  assign w_ireg   = r_ir[12];
  assign w_data   = r_ir[11:0];
  assign w_sr_sel = r_sr[w_ireg];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Registered outputs are loaded one step early so they are valid in the
  // state that owns them (reg_we in EXEC, mux_* in MUXREQ, out_* in RD_*).
  always_comb begin
    w_state_next     = r_state;
    w_ir_next        = r_ir;
    w_sr_next        = r_sr;
    w_rb_next        = r_rb;
    w_cnt_next       = r_cnt;
    w_mux_valid_next = r_mux_valid;
    w_mux_addr_next  = r_mux_addr;
    w_mux_cmd_next   = r_mux_cmd;
    w_mux_data_next  = r_mux_data;
    w_reg_we_next    = 1'b0;
    w_reg_addr_next  = r_reg_addr;
    w_reg_wdata_next = r_reg_wdata;
    w_out_valid_next = r_out_valid;
    w_out_data_next  = r_out_data;
    unique case (r_state)
      S_IDLE: begin
        if (bus_if.instr_valid) begin
          w_ir_next        = bus_if.instr_data;
          w_reg_we_next    = (bus_if.instr_data[15:13] == OP_LDREG);
          w_reg_addr_next  = bus_if.instr_data[REG_AW-1:0];
          w_reg_wdata_next = r_sr[bus_if.instr_data[12]];
          w_state_next     = S_EXEC;
        end
      end
      S_EXEC: begin
        w_state_next = S_IDLE;
        case (w_op)
          OP_SETSR: w_sr_next[w_ireg] = {12'h000, w_data};
          OP_LDSR:  w_sr_next[w_ireg][23:12] = w_data;
          OP_MUX, OP_MUXE: begin
            w_mux_valid_next = 1'b1;
            w_mux_addr_next  = w_data[11:4];
            w_mux_cmd_next   = w_data[3:0];
            w_mux_data_next  = (w_op == OP_MUXE) ? w_sr_sel[11:0] : 12'h000;
            w_state_next     = S_MUXREQ;
          end
          OP_WAIT: begin
            w_cnt_next = w_sr_sel;
            if (w_sr_sel != 24'd0) w_state_next = S_WAIT;
          end
          OP_RDREG: begin
            w_rb_next        = bus_if.reg_rdata;
            w_out_valid_next = 1'b1;
            w_out_data_next  = bus_if.reg_rdata[15:0];
            w_state_next     = S_RD_LO;
          end
          default: ;
        endcase
      end
      S_MUXREQ: begin
        if (bus_if.mux_ready) begin
          w_mux_valid_next = 1'b0;
          w_state_next     = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_cnt != 24'd0) w_cnt_next = r_cnt - 24'd1;
        if (r_cnt <= 24'd1) w_state_next = S_IDLE;
      end
      S_RD_LO: begin
        if (bus_if.out_ready) begin
          w_out_data_next = {8'h00, r_rb[23:16]};
          w_state_next    = S_RD_HI;
        end else begin
          w_out_data_next = r_rb[15:0];
        end
      end
      S_RD_HI: begin
        if (bus_if.out_ready) begin
          w_out_valid_next = 1'b0;
          w_state_next     = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ir        <= '0;
      r_sr        <= '0;
      r_rb        <= '0;
      r_cnt       <= '0;
      r_mux_valid <= 1'b0;
      r_mux_addr  <= '0;
      r_mux_cmd   <= '0;
      r_mux_data  <= '0;
      r_reg_we    <= 1'b0;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_ir        <= w_ir_next;
      r_sr        <= w_sr_next;
      r_rb        <= w_rb_next;
      r_cnt       <= w_cnt_next;
      r_mux_valid <= w_mux_valid_next;
      r_mux_addr  <= w_mux_addr_next;
      r_mux_cmd   <= w_mux_cmd_next;
      r_mux_data  <= w_mux_data_next;
      r_reg_we    <= w_reg_we_next;
      r_reg_addr  <= w_reg_addr_next;
      r_reg_wdata <= w_reg_wdata_next;
      r_out_valid <= w_out_valid_next;
      r_out_data  <= w_out_data_next;
    end
  end

  assign bus_if.instr_ready = (r_state == S_IDLE);
  assign bus_if.busy        = (r_state != S_IDLE);
  assign bus_if.mux_valid   = r_mux_valid;
  assign bus_if.mux_addr    = r_mux_addr;
  assign bus_if.mux_cmd     = r_mux_cmd;
  assign bus_if.mux_data    = r_mux_data;
  assign bus_if.reg_we      = r_reg_we;
  assign bus_if.reg_addr    = r_reg_addr;
  assign bus_if.reg_wdata   = r_reg_wdata;
  assign bus_if.out_valid   = r_out_valid;
  assign bus_if.out_data    = r_out_data;
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed plus randomized instruction stream checked against a
// transaction-level model of scratch registers and the register file.
module tb_instr_sequencer;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [23:0] mdl_sr  [2];
  logic [23:0] mdl_reg [16];
  logic [23:0] dev_reg [16];

  instr_sequencer_if #(.REG_AW(4)) bus();

  instr_sequencer #(.REG_AW(4)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .bus_if (bus)
  );

  assign bus.reg_rdata = dev_reg[bus.reg_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one instruction and follows it until instr_ready returns,
  // acting as device and pipe-out sink. Called and returns at a negedge.
  task automatic run(input logic [2:0] op, input logic ir, input logic [11:0] d,
                     input int stall, input bit noise);
    logic [23:0] src;
    logic [3:0]  a;
    logic [15:0] exp_w [2];
    int lat, exp_lat, exp_we, exp_mux, exp_words;
    int we_cnt, mux_cnt, widx, wstall, bound;
    src = mdl_sr[ir];
    a = d[3:0];
    exp_we = 0; exp_mux = 0; exp_words = 0; exp_lat = 2;
    exp_w[0] = 16'h0; exp_w[1] = 16'h0;
    case (op)
      3'd1: mdl_sr[ir] = {12'h000, d};
      3'd2: mdl_sr[ir][23:12] = d;
      3'd3, 3'd4: begin exp_mux = stall + 1; exp_lat = 3 + stall; end
      3'd5: exp_lat = 2 + int'(src);
      3'd6: begin exp_we = 1; mdl_reg[a] = src; end
      3'd7: begin
        exp_w[0] = mdl_reg[a][15:0];
        exp_w[1] = {8'h00, mdl_reg[a][23:16]};
        exp_words = 2;
        exp_lat = 4 + 2 * stall;
      end
      default: ;
    endcase
    bound = 0;
    while (bus.instr_ready !== 1'b1 && bound < 100) begin
      @(negedge clk);
      bound++;
    end
    chk("ready_before_issue", 32'(bus.instr_ready), 32'd1);
    bus.instr_valid = 1'b1;
    bus.instr_data  = {op, ir, d};
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    lat = 1; we_cnt = 0; mux_cnt = 0; widx = 0; wstall = 0;
    while (lat < 20000) begin
      if (bus.instr_ready === 1'b1) break;
      chk("busy", 32'(bus.busy), 32'd1);
      if (bus.reg_we === 1'b1) begin
        we_cnt++;
        chk("reg_addr", 32'(bus.reg_addr), 32'(a));
        chk("reg_wdata", 32'(bus.reg_wdata), 32'(src));
        dev_reg[bus.reg_addr] = bus.reg_wdata;
      end
      bus.mux_ready = 1'b0;
      if (bus.mux_valid === 1'b1) begin
        mux_cnt++;
        chk("mux_addr", 32'(bus.mux_addr), 32'(d[11:4]));
        chk("mux_cmd", 32'(bus.mux_cmd), 32'(d[3:0]));
        chk("mux_data", 32'(bus.mux_data), (op == 3'd4) ? 32'(src[11:0]) : 32'd0);
        if (mux_cnt > stall) bus.mux_ready = 1'b1;
      end else if (noise) begin
        bus.mux_ready = 1'($urandom_range(0, 1));
      end
      bus.out_ready = 1'b0;
      if (bus.out_valid === 1'b1) begin
        chk("out_data", 32'(bus.out_data), (widx < 2) ? 32'(exp_w[widx]) : 32'hDEAD);
        wstall++;
        if (wstall > stall) begin
          bus.out_ready = 1'b1;
          widx++;
          wstall = 0;
        end
      end else if (noise) begin
        bus.out_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    bus.mux_ready = 1'b0;
    bus.out_ready = 1'b0;
    chk("no_timeout", 32'(lat < 20000), 32'd1);
    chk($sformatf("latency_op%0d", op), 32'(lat), 32'(exp_lat));
    chk("reg_we_pulses", 32'(we_cnt), 32'(exp_we));
    chk("mux_valid_cycles", 32'(mux_cnt), 32'(exp_mux));
    chk("out_words", 32'(widx), 32'(exp_words));
    $display("op=%0d ireg=%0d data=%03h stall=%0d latency=%0d", op, ir, d, stall, lat);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_instr_ready"}, 32'(bus.instr_ready), 32'd1);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_mux_valid"}, 32'(bus.mux_valid), 32'd0);
    chk({tag, "_mux_addr"}, 32'(bus.mux_addr), 32'd0);
    chk({tag, "_mux_cmd"}, 32'(bus.mux_cmd), 32'd0);
    chk({tag, "_mux_data"}, 32'(bus.mux_data), 32'd0);
    chk({tag, "_reg_we"}, 32'(bus.reg_we), 32'd0);
    chk({tag, "_reg_addr"}, 32'(bus.reg_addr), 32'd0);
    chk({tag, "_reg_wdata"}, 32'(bus.reg_wdata), 32'd0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
  endtask

  initial begin
    logic [31:0] v;
    logic [2:0]  op;
    logic        ir;
    logic [11:0] d;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr_data  = 16'h0;
    bus.mux_ready   = 1'b0;
    bus.out_ready   = 1'b0;
    mdl_sr[0] = 24'h0;
    mdl_sr[1] = 24'h0;
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      dev_reg[i] = v[23:0];
      mdl_reg[i] = v[23:0];
    end
    dev_reg[3] = 24'hABCDEF;
    mdl_reg[3] = 24'hABCDEF;
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_no_valid_busy", 32'(bus.busy), 32'd0);

    // LDREG write
    run(3'd1, 1'b0, 12'h0C8, 0, 1'b0);
    run(3'd6, 1'b0, 12'h000, 0, 1'b0);
    // MUX with back-pressure, then MUXE scratch selection
    run(3'd3, 1'b1, {8'h40, 4'h8}, 3, 1'b0);
    run(3'd1, 1'b1, 12'h112, 0, 1'b0);
    run(3'd4, 1'b1, {8'h25, 4'h0}, 0, 1'b0);
    run(3'd6, 1'b0, 12'hF01, 0, 1'b0);
    // Wait timing
    run(3'd1, 1'b0, 12'h3E8, 0, 1'b0);
    run(3'd2, 1'b0, 12'h001, 0, 1'b0);
    run(3'd6, 1'b0, 12'h002, 0, 1'b0);
    run(3'd5, 1'b0, 12'h000, 0, 1'b0);
    run(3'd1, 1'b0, 12'h000, 0, 1'b0);
    run(3'd5, 1'b0, 12'h000, 0, 1'b0);
    // RDREG ordering with pipe-out back-pressure
    run(3'd7, 1'b0, 12'h003, 2, 1'b0);

    // Reset in the middle of a 1000-cycle WAIT
    run(3'd1, 1'b0, 12'h3E8, 0, 1'b0);
    bus.instr_valid = 1'b1;
    bus.instr_data  = {3'd5, 1'b0, 12'h000};
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    repeat (100) @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_reset_outputs("midwait");
    @(negedge clk);
    rst = 1'b0;
    mdl_sr[0] = 24'h0;
    mdl_sr[1] = 24'h0;
    $display("reset asserted mid-WAIT");
    run(3'd6, 1'b0, 12'h005, 0, 1'b0);
    run(3'd1, 1'b1, 12'h777, 0, 1'b0);
    run(3'd6, 1'b1, 12'h006, 0, 1'b0);
    run(3'd7, 1'b0, 12'h006, 1, 1'b0);

    // Randomized stream with spurious ready noise
    for (int n = 0; n < 80; n++) begin
      v  = $urandom;
      op = v[2:0];
      ir = v[3];
      d  = v[15:4];
      if (op == 3'd5 && mdl_sr[ir] > 24'd40)
        run(3'd1, ir, 12'($urandom_range(0, 40)), 0, 1'b1);
      run(op, ir, d, int'($urandom_range(0, 3)), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
